pipeline_stage: RTL and testbench

PIPELINE_STAGE -- requirements
Module: pipeline_stage

---
 rtl/pipeline_stage_pkg.sv | 18 +
 rtl/pipeline_stage_buf.sv | 24 ++
 rtl/pipeline_stage.sv | 152 +++++++++++++++
 tb/tb_pipeline_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stage_pkg.sv
// Shared definitions for pipeline_stage: default payload width and the
// EMPTY/ONE/TWO state encoding, which doubles as the held-entry count.
package pipeline_stage_pkg;

    localparam int DATA_BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // The encoding is chosen so a state maps directly onto the entry count.
    function automatic logic [1:0] state_count(input stage_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipeline_stage_buf.sv
// pipeline_stage_buf: payload register with load enable and synchronous clear
// to RESET_VALUE; clear wins over load.
module pipeline_stage_buf
    import pipeline_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_BUS_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stage.sv
// pipeline_stage: one-entry register slice; with PIPELINE_STAGE_SKID_EN defined
// it becomes a two-entry skid buffer whose in_ready comes straight from a flop.
module pipeline_stage
    import pipeline_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_BUS_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    // Handshake: an entry moves across a side only at a rising edge where that
    // side's valid and ready are both high; once out_valid is raised, out_valid
    // and out_data hold until out_ready takes the entry (or flush/rst drops it).

    stage_state_t          state;
    stage_state_t          state_next;
    logic                  in_fire;
    logic                  out_fire;
    logic                  clear;
    logic                  main_load;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] main_q;

    assign in_fire   = in_valid & in_ready;
    assign out_valid = (state != EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign clear     = rst | flush;
    assign count     = state_count(state);

    // main may still hold a departed entry after ONE -> EMPTY; mask it.
    assign out_data  = out_valid ? main_q : RESET_VALUE;

    pipeline_stage_buf #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk   (clk),
        .clear (clear),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

`ifdef PIPELINE_STAGE_SKID_EN

    logic                  in_ready_q;
    logic                  skid_load;
    logic [DATA_WIDTH-1:0] skid_q;

    assign in_ready = in_ready_q;

    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        main_d     = in_data;
        skid_load  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_load  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load  = 1'b1;
                    state_next = TWO;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_load  = 1'b1;
                    main_d     = skid_q;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // in_ready is registered from the next state, so out_ready never reaches it.
    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != TWO);
        end
    end

    pipeline_stage_buf #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clk   (clk),
        .clear (clear),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

`else

    assign in_ready = !out_valid | out_ready;
    assign main_d   = in_data;

    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        case (state)
            EMPTY, ONE: begin
                if (in_fire) begin
                    main_load  = 1'b1;
                    state_next = ONE;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

`endif

endmodule

// File: tb/tb_pipeline_stage.sv
// Self-checking bench for pipeline_stage at widths 32, 1 and 64, covering the
// default build and, when PIPELINE_STAGE_SKID_EN is defined, the skid build.
`timescale 1ns/1ps
module tb_pipeline_stage;

    localparam logic [63:0] W_RV = 64'hFFFF_0000_FFFF_0000;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 32-bit stage
    logic        s_flush = 0, s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0;
    logic [31:0] s_in_data = '0, s_out_data;
    logic [1:0]  s_count;
    logic [31:0] s_q[$];

    // 1-bit stage
    logic        n_flush = 0, n_in_valid = 0, n_in_ready, n_out_valid, n_out_ready = 0;
    logic [0:0]  n_in_data = '0, n_out_data;
    logic [1:0]  n_count;
    logic [0:0]  n_q[$];

    // 64-bit stage with a non-zero reset value
    logic        w_flush = 0, w_in_valid = 0, w_in_ready, w_out_valid, w_out_ready = 0;
    logic [63:0] w_in_data = '0, w_out_data;
    logic [1:0]  w_count;
    logic [63:0] w_q[$];

    always #5 clk = ~clk;

    pipeline_stage #(.DATA_WIDTH(32)) dut_s (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .count(s_count)
    );

    pipeline_stage #(.DATA_WIDTH(1)) dut_n (
        .clk(clk), .rst(rst), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_data(n_out_data), .count(n_count)
    );

    pipeline_stage #(.DATA_WIDTH(64), .RESET_VALUE(W_RV)) dut_w (
        .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .count(w_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic unexpected(input string tag, input logic [63:0] obs);
        checks++;
        errors++;
        $error("FAIL %s observed=%0h expected=no output", tag, obs);
    endtask

    // Scoreboards: accepted inputs are queued, output transfers pop and compare.
    always @(negedge clk) begin
        if (rst || s_flush) begin
            s_q.delete();
        end else begin
            check("s_count_vs_model", 64'(s_count), 64'(s_q.size()));
            check("s_out_valid_vs_model", 64'(s_out_valid), 64'(s_q.size() != 0));
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) unexpected("s_unexpected_out", 64'(s_out_data));
                else check("s_out_data", 64'(s_out_data), 64'(s_q.pop_front()));
            end
            if (s_in_valid && s_in_ready) s_q.push_back(s_in_data);
        end
    end

    always @(negedge clk) begin
        if (rst || n_flush) begin
            n_q.delete();
        end else begin
            if (n_out_valid && n_out_ready) begin
                if (n_q.size() == 0) unexpected("n_unexpected_out", 64'(n_out_data));
                else check("n_out_data", 64'(n_out_data), 64'(n_q.pop_front()));
            end
            if (n_in_valid && n_in_ready) n_q.push_back(n_in_data);
        end
    end

    always @(negedge clk) begin
        if (rst || w_flush) begin
            w_q.delete();
        end else begin
            if (w_out_valid && w_out_ready) begin
                if (w_q.size() == 0) unexpected("w_unexpected_out", w_out_data);
                else check("w_out_data", w_out_data, w_q.pop_front());
            end
            if (w_in_valid && w_in_ready) w_q.push_back(w_in_data);
        end
    end

    task automatic send_w(input logic [63:0] d);
        bit taken;
        taken = 0;
        w_in_valid = 1'b1;
        w_in_data  = d;
        for (int k = 0; k < 20 && !taken; k++) begin
            @(negedge clk);
            taken = w_in_ready;
        end
        if (!taken) unexpected("w_send_timeout", d);
        @(posedge clk); #1;
        w_in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [5:0] pat;

        // Reset: two cycles, then idle state on every instance.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(s_out_valid), 64'd0);
        check("rst_in_ready", 64'(s_in_ready), 64'd1);
        check("rst_count", 64'(s_count), 64'd0);
        check("rst_out_data", 64'(s_out_data), 64'd0);
        check("rst_n_out_valid", 64'(n_out_valid), 64'd0);
        check("rst_w_out_data", w_out_data, W_RV);
        check("rst_w_count", 64'(w_count), 64'd0);

        // Streaming 1..4 with out_ready high: 1-cycle latency, no bubbles.
        s_out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            s_in_valid = (i <= 4);
            s_in_data  = 32'(i);
            @(negedge clk);
            if (i >= 2) begin
                check("stream_out_valid", 64'(s_out_valid), 64'd1);
                check("stream_out_data", 64'(s_out_data), 64'(i - 1));
            end
        end

`ifdef PIPELINE_STAGE_SKID_EN
        // Backpressure fills both entries; in_ready drops, head stays put.
        @(posedge clk); #1;
        s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'hA;
        @(posedge clk); #1;
        s_in_data = 32'hB;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("bp_count_two", 64'(s_count), 64'd2);
        check("bp_in_ready_low", 64'(s_in_ready), 64'd0);
        check("bp_head", 64'(s_out_data), 64'hA);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_head_stable", 64'(s_out_data), 64'hA);
        @(posedge clk); #1;
        s_out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_first", 64'(s_out_data), 64'hA);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_drain_second", 64'(s_out_data), 64'hB);
        check("bp_count_one", 64'(s_count), 64'd1);
        check("bp_in_ready_back", 64'(s_in_ready), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_count_zero", 64'(s_count), 64'd0);

        // Fill to TWO ahead of the flush.
        @(posedge clk); #1;
        s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'h21;
        @(posedge clk); #1;
        s_in_data = 32'h22;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("fl_pre_count", 64'(s_count), 64'd2);
`else
        // One entry held under backpressure blocks input combinationally.
        @(posedge clk); #1;
        s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'h11;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("ns_count_one", 64'(s_count), 64'd1);
        check("ns_in_ready_low", 64'(s_in_ready), 64'd0);
        check("ns_head", 64'(s_out_data), 64'h11);
        @(posedge clk); #1;
        @(negedge clk);
        check("ns_head_stable", 64'(s_out_data), 64'h11);
        @(posedge clk); #1;
        s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 32'h5;
        @(negedge clk);
        check("ns_in_ready_same_cycle", 64'(s_in_ready), 64'd1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("ns_next_data", 64'(s_out_data), 64'h5);
        check("ns_next_valid", 64'(s_out_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("ns_count_zero", 64'(s_count), 64'd0);

        // Hold one entry ahead of the flush.
        @(posedge clk); #1;
        s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'h21;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("fl_pre_count", 64'(s_count), 64'd1);
`endif

        // Flush beats a concurrent in_fire and out_fire.
        @(posedge clk); #1;
        s_flush = 1'b1; s_in_valid = 1'b1; s_in_data = 32'h99; s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_flush = 1'b0; s_in_valid = 1'b0;
        @(negedge clk);
        check("fl_count", 64'(s_count), 64'd0);
        check("fl_out_valid", 64'(s_out_valid), 64'd0);
        check("fl_out_data", 64'(s_out_data), 64'd0);
        check("fl_in_ready", 64'(s_in_ready), 64'd1);

        // Random traffic with occasional flushes; the scoreboard does the checking.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            s_in_valid  = 1'($urandom_range(0, 1));
            s_out_ready = ($urandom_range(0, 3) != 0);
            s_in_data   = $urandom;
            s_flush     = ($urandom_range(0, 40) == 0);
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
        for (int k = 0; k < 10 && s_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("s_drain", 64'(s_q.size()), 64'd0);

        // 1-bit stage: bit pattern streamed in order.
        pat = 6'b101101;
        n_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_in_valid = 1'b1;
            n_in_data  = pat[i];
            @(negedge clk);
            check("n_in_ready", 64'(n_in_ready), 64'd1);
        end
        @(posedge clk); #1;
        n_in_valid = 1'b0;

        // 64-bit stage: all-ones held under backpressure, then a second word.
        send_w(64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("w_head", w_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        check("w_head_stable", w_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        w_out_ready = 1'b1;
        send_w(64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check("w_second", w_out_data, 64'h0123_4567_89AB_CDEF);
        repeat (3) @(posedge clk);
        #1;
        check("n_drain", 64'(n_q.size()), 64'd0);
        check("n_count_end", 64'(n_count), 64'd0);
        check("w_drain", 64'(w_q.size()), 64'd0);
        check("w_empty_data", w_out_data, W_RV);
        check("w_empty_valid", 64'(w_out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
